// File: rtl/hazard_stall_unit_pkg.sv
// rtl/hazard_stall_unit_pkg.sv - shared pipeline constants and stall-cause encoding
package hazard_stall_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  // Stall cause, exported so trace/debug logic can see why ID held.
  typedef enum logic [1:0] {
    CAUSE_RUN    = 2'd0,
    CAUSE_RAW    = 2'd1,
    CAUSE_FLUSH  = 2'd2,
    CAUSE_FREEZE = 2'd3
  } stall_cause_e;

  // Resolve the per-cycle priority: freeze > flush > raw > run.
  function automatic stall_cause_e stall_cause(input logic mem_busy,
                                               input logic branch_taken,
                                               input logic raw);
    if (mem_busy)          return CAUSE_FREEZE;
    else if (branch_taken) return CAUSE_FLUSH;
    else if (raw)          return CAUSE_RAW;
    else                   return CAUSE_RUN;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - ID-stage hazard handshake between pipeline and stall unit
interface hazard_stall_unit_if;
  import hazard_stall_unit_pkg::*;

  logic [REG_W-1:0] IF_ID_R1;
  logic [REG_W-1:0] IF_ID_R2;
  logic [REG_W-1:0] IF_ID_Rd;
  logic             IF_ID_RegWrite;
  logic             IF_ID_MemRead;
  logic             IF_ID_valid;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_bubble;
  logic             issue;

  // Pipeline side: presents the ID instruction and global events.
  modport master (
    output IF_ID_R1, IF_ID_R2, IF_ID_Rd, IF_ID_RegWrite, IF_ID_MemRead,
           IF_ID_valid, branch_taken, mem_busy,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, issue
  );

  // Stall unit side: returns the pipeline enables.
  modport slave (
    input  IF_ID_R1, IF_ID_R2, IF_ID_Rd, IF_ID_RegWrite, IF_ID_MemRead,
           IF_ID_valid, branch_taken, mem_busy,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, issue
  );

endinterface

// File: rtl/hazard_stall_unit_scoreboard.sv
// rtl/hazard_stall_unit_scoreboard.sv - per-register countdown of in-flight writers
module reg_scoreboard
  import hazard_stall_unit_pkg::*;
#(
  parameter int LOAD_EXTRA = 0,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_advance,
  input  logic             i_alloc,
  input  logic             i_alloc_load,
  input  logic [REG_W-1:0] i_alloc_rd,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  output logic             o_rs1_busy,
  output logic             o_rs2_busy
);

  localparam logic [CNT_W-1:0] ALU_LAT  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_LAT = CNT_W'(1 + LOAD_EXTRA);

  logic [CNT_W-1:0] r_cnt [1:31];
  logic [31:0]      w_busy;

  // Age every in-flight writer by one stage; a new writer overrides its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) r_cnt[r] <= '0;
    end else if (i_advance) begin
      for (int r = 1; r < 32; r++) begin
        if (i_alloc && (i_alloc_rd == REG_W'(r)))
          r_cnt[r] <= i_alloc_load ? LOAD_LAT : ALU_LAT;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  // Flatten to a busy vector; bit 0 stays low so x0 never stalls.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < 32; r++) w_busy[r] = (r_cnt[r] != '0);
  end

  assign o_rs1_busy = w_busy[i_rs1];
  assign o_rs2_busy = w_busy[i_rs2];

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - ID-stage RAW stall, branch flush and memory freeze sequencer
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int LOAD_EXTRA = 0,
  parameter int CNT_W      = 2,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  hazard_stall_unit_if.slave bus,
  output logic [PERF_W-1:0] stall_cycles
);

  logic              w_rs1_busy;
  logic              w_rs2_busy;
  logic              w_raw;
  logic              w_alloc;
  logic              w_pc_write;
  logic              w_issue;
  stall_cause_e      w_cause;
  logic [PERF_W-1:0] r_stall_cycles;

  reg_scoreboard #(
    .LOAD_EXTRA(LOAD_EXTRA),
    .CNT_W     (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_advance   (!bus.mem_busy),
    .i_alloc     (w_alloc),
    .i_alloc_load(bus.IF_ID_MemRead),
    .i_alloc_rd  (bus.IF_ID_Rd),
    .i_rs1       (bus.IF_ID_R1),
    .i_rs2       (bus.IF_ID_R2),
    .o_rs1_busy  (w_rs1_busy),
    .o_rs2_busy  (w_rs2_busy)
  );

  assign w_raw   = bus.IF_ID_valid && (w_rs1_busy || w_rs2_busy);
  assign w_cause = stall_cause(bus.mem_busy, bus.branch_taken, w_raw);
  assign w_alloc = w_issue && bus.IF_ID_RegWrite && (bus.IF_ID_Rd != REG_X0);

  // Map the winning stall cause onto the pipeline enables.
  always_comb begin
    w_pc_write       = 1'b1;
    bus.IF_ID_write  = 1'b1;
    bus.IF_ID_flush  = 1'b0;
    bus.ID_EX_bubble = 1'b0;
    w_issue          = 1'b0;
    case (w_cause)
      CAUSE_FREEZE: begin
        w_pc_write      = 1'b0;
        bus.IF_ID_write = 1'b0;
      end
      CAUSE_FLUSH: begin
        bus.IF_ID_flush  = 1'b1;
        bus.ID_EX_bubble = 1'b1;
      end
      CAUSE_RAW: begin
        w_pc_write       = 1'b0;
        bus.IF_ID_write  = 1'b0;
        bus.ID_EX_bubble = 1'b1;
      end
      default: w_issue = bus.IF_ID_valid;
    endcase
  end

  assign bus.pc_write = w_pc_write;
  assign bus.issue    = w_issue;

  // Count every cycle the PC is held, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cycles <= '0;
    else if (!w_pc_write && (r_stall_cycles != '1))
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

  localparam logic [4:0] O_RUN_I = 5'b11001;
  localparam logic [4:0] O_RUN_N = 5'b11000;
  localparam logic [4:0] O_RAW   = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_FRZ   = 5'b00000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid, rw, mr, br, busy;
  logic [4:0] r1, r2, rd;
  logic [15:0] stall0;
  logic [2:0]  stall1;

  int checks = 0;
  int errors = 0;

  int t;
  int ready0 [32];
  int ready1 [32];
  int perf0, perf1;

  always #5 clk = ~clk;

  hazard_stall_unit_if bus0 ();
  hazard_stall_unit_if bus1 ();

  assign bus0.IF_ID_R1 = r1;       assign bus1.IF_ID_R1 = r1;
  assign bus0.IF_ID_R2 = r2;       assign bus1.IF_ID_R2 = r2;
  assign bus0.IF_ID_Rd = rd;       assign bus1.IF_ID_Rd = rd;
  assign bus0.IF_ID_RegWrite = rw; assign bus1.IF_ID_RegWrite = rw;
  assign bus0.IF_ID_MemRead = mr;  assign bus1.IF_ID_MemRead = mr;
  assign bus0.IF_ID_valid = valid; assign bus1.IF_ID_valid = valid;
  assign bus0.branch_taken = br;   assign bus1.branch_taken = br;
  assign bus0.mem_busy = busy;     assign bus1.mem_busy = busy;

  wire [4:0] outs0 = {bus0.pc_write, bus0.IF_ID_write, bus0.IF_ID_flush, bus0.ID_EX_bubble, bus0.issue};
  wire [4:0] outs1 = {bus1.pc_write, bus1.IF_ID_write, bus1.IF_ID_flush, bus1.ID_EX_bubble, bus1.issue};

  hazard_stall_unit #(.LOAD_EXTRA(0), .CNT_W(2), .PERF_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .stall_cycles(stall0));
  hazard_stall_unit #(.LOAD_EXTRA(1), .CNT_W(2), .PERF_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .stall_cycles(stall1));

  // Reference: a register is readable once the unfrozen-cycle clock t reaches its ready time.
  function automatic logic [4:0] exp_outs(input int extra);
    bit hz1, hz2;
    hz1 = (r1 != 0) && (((extra != 0) ? ready1[r1] : ready0[r1]) > t);
    hz2 = (r2 != 0) && (((extra != 0) ? ready1[r2] : ready0[r2]) > t);
    if (busy) return 5'b00000;
    if (br) return 5'b11110;
    if (valid && (hz1 || hz2)) return 5'b00010;
    return {4'b1100, valid};
  endfunction

  task automatic model_clear();
    t = 0; perf0 = 0; perf1 = 0;
    for (int i = 0; i < 32; i++) begin ready0[i] = 0; ready1[i] = 0; end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic m, input logic brk, input logic bsy);
    valid = v; r1 = a; r2 = b; rd = d; rw = w; mr = m; br = brk; busy = bsy;
  endtask

  task automatic step();
    logic [4:0] e0, e1;
    e0 = exp_outs(0);
    e1 = exp_outs(1);
    @(posedge clk);
    if (!busy) begin
      if (e0[0] && rw && rd != 0) ready0[rd] = t + 2;
      if (e1[0] && rw && rd != 0) ready1[rd] = t + 2 + (mr ? 1 : 0);
      t++;
    end
    if (!e0[4] && perf0 < 65535) perf0++;
    if (!e1[4] && perf1 < 7) perf1++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    drive(1, 3, 4, 5, 1, 0, 0, 0);
    @(negedge clk); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL reset_outs0 got %b exp %b", outs0, O_RUN_I); end
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL reset_stall0 got %0d exp 0", stall0); end
    checks++; if (stall1 !== 3'd0) begin errors++; $display("FAIL reset_stall1 got %0d exp 0", stall1); end
    do_reset();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 2, 5, 1, 0, 0, 0); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL b2b_producer got %b exp %b", outs0, O_RUN_I); end
    step();
    drive(1, 5, 1, 6, 1, 0, 0, 0); #1;
    checks++; if (outs0 !== O_RAW) begin errors++; $display("FAIL b2b_stall got %b exp %b", outs0, O_RAW); end
    step(); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL b2b_issue got %b exp %b", outs0, O_RUN_I); end
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (stall0 !== 16'd1) begin errors++; $display("FAIL b2b_stall_cycles got %0d exp 1", stall0); end
  endtask

  task automatic test_distance2();
    logic [4:0] exp_seq [3];
    exp_seq[0] = O_RUN_I; exp_seq[1] = O_RUN_N; exp_seq[2] = O_RUN_I;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(1, 1, 2, 5, 1, 0, 0, 0);
        1: drive(0, 0, 0, 0, 0, 0, 0, 0);
        default: drive(1, 5, 2, 7, 1, 0, 0, 0);
      endcase
      #1;
      checks++; if (outs0 !== exp_seq[i]) begin errors++; $display("FAIL dist2_cycle%0d got %b exp %b", i, outs0, exp_seq[i]); end
      step();
    end
    checks++; if (stall0 !== 16'd0) begin errors++; $display("FAIL dist2_stall_cycles got %0d exp 0", stall0); end
  endtask

  task automatic test_x0();
    do_reset();
    drive(1, 1, 2, 0, 1, 1, 0, 0); #1;
    step();
    drive(1, 0, 0, 3, 1, 0, 0, 0); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL x0_dut0 got %b exp %b", outs0, O_RUN_I); end
    checks++; if (outs1 !== O_RUN_I) begin errors++; $display("FAIL x0_dut1 got %b exp %b", outs1, O_RUN_I); end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 2, 5, 1, 0, 0, 0); step();
    drive(1, 5, 0, 8, 1, 0, 1, 0); #1;
    checks++; if (outs0 !== O_FLUSH) begin errors++; $display("FAIL flush_outs got %b exp %b", outs0, O_FLUSH); end
    step();
    drive(1, 8, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL flush_killed_rd got %b exp %b", outs0, O_RUN_I); end
    step();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 1, 2, 5, 1, 0, 0, 0); step();
    drive(1, 5, 0, 6, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs0 !== O_FRZ) begin errors++; $display("FAIL freeze_cycle%0d got %b exp %b", i, outs0, O_FRZ); end
      step();
    end
    checks++; if (stall0 !== 16'd3) begin errors++; $display("FAIL freeze_stall_cycles got %0d exp 3", stall0); end
    busy = 1'b0; #1;
    checks++; if (outs0 !== O_RAW) begin errors++; $display("FAIL freeze_release_raw got %b exp %b", outs0, O_RAW); end
    step(); #1;
    checks++; if (outs0 !== O_RUN_I) begin errors++; $display("FAIL freeze_release_issue got %b exp %b", outs0, O_RUN_I); end
    step();
    checks++; if (stall0 !== 16'd4) begin errors++; $display("FAIL freeze_total got %0d exp 4", stall0); end
  endtask

  task automatic test_load();
    logic [4:0] e0 [3];
    logic [4:0] e1 [3];
    e0[0] = O_RAW; e0[1] = O_RUN_I; e0[2] = O_RUN_I;
    e1[0] = O_RAW; e1[1] = O_RAW;   e1[2] = O_RUN_I;
    do_reset();
    drive(1, 1, 0, 9, 1, 1, 0, 0); step();
    drive(1, 2, 9, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (outs0 !== e0[i]) begin errors++; $display("FAIL load_dut0_cycle%0d got %b exp %b", i, outs0, e0[i]); end
      checks++; if (outs1 !== e1[i]) begin errors++; $display("FAIL load_dut1_cycle%0d got %b exp %b", i, outs1, e1[i]); end
      step();
    end
    checks++; if (stall1 !== 3'd2) begin errors++; $display("FAIL load_stall_cycles got %0d exp 2", stall1); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1, 1, 0, 9, 1, 1, 0, 0); step();
    drive(1, 9, 0, 0, 0, 0, 0, 0); step();
    #2;
    checks++; if (outs1 !== O_RAW) begin errors++; $display("FAIL midrst_pre got %b exp %b", outs1, O_RAW); end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (outs1 !== O_RUN_I) begin errors++; $display("FAIL midrst_outs got %b exp %b", outs1, O_RUN_I); end
    checks++; if (stall1 !== 3'd0) begin errors++; $display("FAIL midrst_stall got %0d exp 0", stall1); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (10) step();
    checks++; if (stall1 !== 3'd7) begin errors++; $display("FAIL sat_dut1 got %0d exp 7", stall1); end
    checks++; if (stall0 !== 16'd10) begin errors++; $display("FAIL sat_dut0 got %0d exp 10", stall0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      #1;
      checks++; if (outs0 !== exp_outs(0)) begin errors++; $display("FAIL rand_outs0 cyc%0d got %b exp %b", i, outs0, exp_outs(0)); end
      checks++; if (outs1 !== exp_outs(1)) begin errors++; $display("FAIL rand_outs1 cyc%0d got %b exp %b", i, outs1, exp_outs(1)); end
      checks++; if (int'(stall0) != perf0) begin errors++; $display("FAIL rand_stall0 cyc%0d got %0d exp %0d", i, stall0, perf0); end
      checks++; if (int'(stall1) != perf1) begin errors++; $display("FAIL rand_stall1 cyc%0d got %0d exp %0d", i, stall1, perf1); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_distance2();
    test_x0();
    test_flush();
    test_freeze();
    test_load();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Producer-side counterpart of the EX-stage forwarding logic. The forwarding path supplies operands only from MEM/WB; this block tracks in-flight register writers in a per-register scoreboard.
- It stalls the ID-stage instruction until each of its sources is forwardable from MEM/WB or readable from the register file.
- It also sequences branch flushes and data-memory freezes for the 5-stage pipeline (IF, ID, EX, MEM, WB), and counts stall cycles for performance monitoring.

Parameters:
- LOAD_EXTRA, 0, additional busy cycles a load result adds beyond an ALU result (0 = load data latched in MEM/WB).
- CNT_W, 2, width of each scoreboard countdown; must hold 1+LOAD_EXTRA.
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- IF_ID_R1  in  5  rs1 of instruction in ID
- IF_ID_R2  in  5  rs2 of instruction in ID
- IF_ID_Rd  in  5  rd of instruction in ID
- IF_ID_RegWrite  in  1  ID instruction writes rd
- IF_ID_MemRead  in  1  ID instruction is a load
- IF_ID_valid  in  1  ID holds a real instruction (not a bubble)
- branch_taken  in  1  branch/jump in EX redirects PC this cycle
- mem_busy  in  1  data memory not ready; whole pipeline must hold
- pc_write  out  1  PC may update
- IF_ID_write  out  1  IF/ID register may load
- IF_ID_flush  out  1  IF/ID loads a NOP
- ID_EX_bubble  out  1  ID/EX loads a NOP instead of the ID instruction
- issue  out  1  ID instruction advances to EX this cycle
- stall_cycles  out  PERF_W  saturating count of cycles with pc_write=0

Behaviour:
- Scoreboard: cnt[r] for r=1..31, each CNT_W bits; x0 is never tracked and always reads 0. Reset clears all entries and stall_cycles.
- raw = IF_ID_valid and ((IF_ID_R1!=0 and cnt[IF_ID_R1]!=0) or (IF_ID_R2!=0 and cnt[IF_ID_R2]!=0)).
- Priority per cycle is freeze > flush > raw > run. Outputs are combinational from state and inputs:
  - freeze (mem_busy=1): pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, issue=0; scoreboard holds.
  - flush (branch_taken=1, mem_busy=0): pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1, issue=0. The ID instruction is killed and never enters the scoreboard; a coincident raw is ignored.
  - raw (raw=1, neither of the above): pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=1, issue=0.
  - run: pc_write=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_bubble=0, issue=IF_ID_valid.
- Scoreboard update on each unfrozen clock edge:
  - Every nonzero cnt decrements by 1.
  - Then, if issue=1 and IF_ID_RegWrite=1 and IF_ID_Rd!=0, cnt[IF_ID_Rd] loads 1 (ALU op) or 1+LOAD_EXTRA (load). The load overrides the decrement for that entry.
- Timing with LOAD_EXTRA=0: a dependent instruction directly behind its producer stalls exactly 1 cycle, then issues as the producer enters MEM/WB. A dependency at distance >=2 causes no stall.
- System requirement: the register file is write-first (WB write visible to the same-cycle ID read). This block does not cover a WB-stage producer.
- stall_cycles increments on every cycle with pc_write=0 (raw or freeze) and saturates at all-ones.
- Reset asserted mid-stall or mid-freeze: outputs immediately take run values with an empty scoreboard.

Decomposition:
- Shared pipeline package holds:
  - REG_W=5 and the x0 index constant;
  - the 2-bit stall-cause encoding (RUN, RAW, FLUSH, FREEZE), exported for debug/trace.
- One natural sub-module: reg_scoreboard, the 31-entry countdown array with its issue/load and decrement logic. The priority/output logic stays in the top.

Test Plan:
- add x5 then immediately add x6,x5,x1 -> 1 cycle with pc_write=0, ID_EX_bubble=1; consumer issues next cycle; stall_cycles=1.
- add x5, nop, sub x7,x5,x2 -> no stall, issue=1 every cycle, stall_cycles=0.
- Producer writes x0, consumer reads x0 back-to-back -> no stall.
- Dependent instruction in ID with branch_taken=1 the same cycle -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; cnt unchanged.
- Stall in progress with mem_busy=1 for 3 cycles -> all write enables 0, cnt frozen at 1; stall_cycles grows by 3; after release 1 more raw stall cycle.
- LOAD_EXTRA=1, lw x9 then use of x9 -> 2 stall cycles. Reset pulsed mid-stall -> outputs return to run, stall_cycles=0.
